instr_fetch: RTL and testbench

- Instruction fetch stage that drives the program ROM address and enable.
- Buffers fetched 16-bit instruction words, each with its PC, in a small prefetch FIFO.
- Presents words to the instruction decoder over a valid/ready handshake.
- Replaces the free-running program counter: adds start, jump (flush and redirect), halt detection and back-pressure.

---
 rtl/instr_fetch_pkg.sv | 27 ++
 rtl/instr_fetch_if.sv | 31 +++
 rtl/instr_fetch_fifo.sv | 78 +++++++
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_pkg
//  Description : Instruction encoding and fetch-FSM state definitions.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    // Instruction word layout: [15:12] R1 R0, [11:8] opcode, [7:0] data
    localparam int OPC_HI = 11;
    localparam int OPC_LO = 8;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_LOAD = 4'h1;
    localparam logic [3:0] OPC_ADD  = 4'h2;
    localparam logic [3:0] OPC_JMP  = 4'hC;
    localparam logic [3:0] HALT_OPC = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : ROM, redirect and decoder-handshake signals of the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_oe;
    logic [INSTR_W-1:0] rom_data;
    logic               jump_en;
    logic [ADDR_W-1:0]  jump_addr;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;

    modport master (
        output rom_addr, rom_oe, instr_valid, instr_data, instr_pc,
        input  rom_data, jump_en, jump_addr, instr_ready
    );

    modport slave (
        input  rom_addr, rom_oe, instr_valid, instr_data, instr_pc,
        output rom_data, jump_en, jump_addr, instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Prefetch FIFO with registered head word; flush beats push.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push,
    input  wire logic                   pop,
    input  wire logic                   flush,
    input  wire logic [WIDTH-1:0]       din,
    output logic      [WIDTH-1:0]       dout,
    output logic      [$clog2(DEPTH):0] count,
    output logic                        empty,
    output logic                        full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_dout;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_next;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign w_pop     = pop && !empty;
    assign w_push    = push && (!full || w_pop);
    assign w_rd_next = r_rd_ptr + PTR_W'(1);
    assign count     = r_count;
    assign dout      = r_dout;

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= w_rd_next;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Head register tracks mem[rd_ptr]; a lone word bypasses the array.
            if (w_pop) begin
                if (r_count > CNT_W'(1)) r_dout <= r_mem[w_rd_next];
                else if (w_push)         r_dout <= din;
                else                     r_dout <= '0;
            end else if (w_push && empty) begin
                r_dout <= din;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Fetch stage: PC/FSM driving the ROM, prefetch FIFO to decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int         ADDR_W   = 5,
    parameter int         INSTR_W  = 16,
    parameter int         DEPTH    = 4,
    parameter logic [3:0] HALT_OPC = instr_fetch_pkg::HALT_OPC
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   start,
    instr_fetch_if.master               bus,
    output logic                        halted,
    output logic      [$clog2(DEPTH):0] fifo_cnt_dbg
);
    import instr_fetch_pkg::*;

    localparam int ENTRY_W = ADDR_W + INSTR_W;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_next;
    logic                w_fetch;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_empty;
    logic                w_full;
    logic [ENTRY_W-1:0]  w_head;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   ({r_pc, bus.rom_data}),
        .dout  (w_head),
        .count (fifo_cnt_dbg),
        .empty (w_empty),
        .full  (w_full)
    );

    assign bus.instr_valid = !w_empty;
    assign bus.instr_data  = w_head[INSTR_W-1:0];
    assign bus.instr_pc    = w_head[ENTRY_W-1:INSTR_W];
    assign bus.rom_addr    = r_pc;
    assign bus.rom_oe      = w_fetch;
    assign halted          = (r_state == S_HALTED);
    assign w_pop           = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_fetch      = 1'b0;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                    w_pc_next    = '0;
                end
            end
            S_RUN: begin
                // A full FIFO still fetches when the head leaves this cycle.
                w_fetch = !w_full || w_pop;
                if (bus.jump_en) begin
                    w_flush   = 1'b1;
                    w_pc_next = bus.jump_addr;
                end else if (w_fetch) begin
                    w_push = 1'b1;
                    if (bus.rom_data[OPC_HI:OPC_LO] == HALT_OPC) begin
                        w_state_next = S_DRAIN;
                    end else begin
                        w_pc_next = r_pc + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (bus.jump_en) begin
                    w_flush      = 1'b1;
                    w_pc_next    = bus.jump_addr;
                    w_state_next = S_RUN;
                end else if (w_empty) begin
                    w_state_next = S_HALTED;
                end
            end
            S_HALTED: begin
                if (start) begin
                    w_flush      = 1'b1;
                    w_pc_next    = '0;
                    w_state_next = S_RUN;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed self-checking bench for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       halted;
    logic [2:0] fifo_cnt_dbg;
    logic [15:0] rom [32];
    int vectors = 0;
    int errors  = 0;

    instr_fetch_if #(.ADDR_W(5), .INSTR_W(16)) bus ();

    instr_fetch #(
        .ADDR_W   (5),
        .INSTR_W  (16),
        .DEPTH    (4),
        .HALT_OPC (4'hF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .halted       (halted),
        .fifo_cnt_dbg (fifo_cnt_dbg)
    );

    always #5 clk = ~clk;
    assign bus.rom_data = rom[bus.rom_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rom();
        for (int i = 0; i < 32; i++) rom[i] = 16'h0C00 | 16'(i);
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0;
        bus.jump_en = 1'b0; bus.jump_addr = '0; bus.instr_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        vectors++; if (bus.rom_oe !== 1'b0) begin errors++; $display("FAIL reset_rom_oe: got %b want 0", bus.rom_oe); end
        vectors++; if (bus.rom_addr !== 5'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d want 0", bus.rom_addr); end
        vectors++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
        vectors++; if (bus.instr_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", bus.instr_data); end
        vectors++; if (bus.instr_pc !== 5'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", bus.instr_pc); end
        vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        vectors++; if (fifo_cnt_dbg !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", fifo_cnt_dbg); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (bus.rom_oe !== 1'b0) begin errors++; $display("FAIL idle_no_fetch: cycle %0d got rom_oe %b want 0", i, bus.rom_oe); end
        end
    endtask

    task automatic test_stream();
        apply_reset();
        bus.instr_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if (bus.rom_oe !== 1'b1 || bus.rom_addr !== 5'd0) begin errors++; $display("FAIL stream_first_fetch: got oe %b addr %0d want oe 1 addr 0", bus.rom_oe, bus.rom_addr); end
        vectors++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b want 0", bus.instr_valid); end
        for (int i = 0; i < 6; i++) begin
            logic [15:0] e_data;
            e_data = 16'h0C00 | 16'(i);
            tick();
            vectors++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 5'(i) || bus.instr_data !== e_data) begin
                errors++;
                $display("FAIL stream_word: got v %b pc %0d data %h want v 1 pc %0d data %h", bus.instr_valid, bus.instr_pc, bus.instr_data, i, e_data);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        vectors++; if (fifo_cnt_dbg !== 3'd4) begin errors++; $display("FAIL bp_full_cnt: got %0d want 4", fifo_cnt_dbg); end
        vectors++; if (bus.rom_oe !== 1'b0 || bus.rom_addr !== 5'd4) begin errors++; $display("FAIL bp_stall: got oe %b addr %0d want oe 0 addr 4", bus.rom_oe, bus.rom_addr); end
        tick();
        vectors++; if (bus.instr_pc !== 5'd0 || bus.instr_data !== 16'h0C00 || fifo_cnt_dbg !== 3'd4) begin errors++; $display("FAIL bp_hold: got pc %0d data %h cnt %0d want pc 0 data 0c00 cnt 4", bus.instr_pc, bus.instr_data, fifo_cnt_dbg); end
        bus.instr_ready = 1'b1;
        #1;
        vectors++; if (bus.rom_oe !== 1'b1) begin errors++; $display("FAIL bp_resume_oe: got %b want 1", bus.rom_oe); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++;
            if (bus.instr_pc !== 5'(k) || fifo_cnt_dbg !== 3'd4) begin
                errors++;
                $display("FAIL bp_drain: got pc %0d cnt %0d want pc %0d cnt 4", bus.instr_pc, fifo_cnt_dbg, k);
            end
        end
    endtask

    task automatic test_halt();
        apply_reset();
        rom[2] = 16'h0F00;
        bus.instr_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        vectors++; if (bus.instr_pc !== 5'd1 || bus.rom_addr !== 5'd2 || bus.rom_oe !== 1'b1) begin errors++; $display("FAIL halt_fetch2: got pc %0d addr %0d oe %b want pc 1 addr 2 oe 1", bus.instr_pc, bus.rom_addr, bus.rom_oe); end
        tick();
        vectors++; if (bus.instr_pc !== 5'd2 || bus.instr_data !== 16'h0F00) begin errors++; $display("FAIL halt_word: got pc %0d data %h want pc 2 data 0f00", bus.instr_pc, bus.instr_data); end
        vectors++; if (bus.rom_oe !== 1'b0 || bus.rom_addr !== 5'd2 || halted !== 1'b0) begin errors++; $display("FAIL halt_drain: got oe %b addr %0d halted %b want 0 2 0", bus.rom_oe, bus.rom_addr, halted); end
        tick();
        vectors++; if (bus.instr_valid !== 1'b0 || bus.rom_oe !== 1'b0) begin errors++; $display("FAIL halt_empty: got v %b oe %b want 0 0", bus.instr_valid, bus.rom_oe); end
        tick();
        vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", halted); end
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if (halted !== 1'b0 || bus.rom_oe !== 1'b1 || bus.rom_addr !== 5'd0) begin errors++; $display("FAIL halt_restart: got halted %b oe %b addr %0d want 0 1 0", halted, bus.rom_oe, bus.rom_addr); end
        tick();
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 5'd0) begin errors++; $display("FAIL halt_restart_word: got v %b pc %0d want v 1 pc 0", bus.instr_valid, bus.instr_pc); end
        load_rom();
    endtask

    task automatic test_jump();
        apply_reset();
        bus.jump_en = 1'b1; bus.jump_addr = 5'd9;
        tick(); tick();
        vectors++; if (bus.rom_oe !== 1'b0 || bus.rom_addr !== 5'd0) begin errors++; $display("FAIL jump_idle: got oe %b addr %0d want oe 0 addr 0", bus.rom_oe, bus.rom_addr); end
        bus.jump_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        vectors++; if (fifo_cnt_dbg !== 3'd3) begin errors++; $display("FAIL jump_prefill: got cnt %0d want 3", fifo_cnt_dbg); end
        bus.instr_ready = 1'b1;
        tick();
        vectors++; if (fifo_cnt_dbg !== 3'd3 || bus.instr_pc !== 5'd1) begin errors++; $display("FAIL jump_hold123: got cnt %0d pc %0d want cnt 3 pc 1", fifo_cnt_dbg, bus.instr_pc); end
        bus.instr_ready = 1'b0; bus.jump_en = 1'b1; bus.jump_addr = 5'd5;
        tick();
        bus.jump_en = 1'b0;
        vectors++; if (bus.instr_valid !== 1'b0 || fifo_cnt_dbg !== 3'd0 || bus.rom_addr !== 5'd5) begin errors++; $display("FAIL jump_flush: got v %b cnt %0d addr %0d want v 0 cnt 0 addr 5", bus.instr_valid, fifo_cnt_dbg, bus.rom_addr); end
        bus.instr_ready = 1'b1;
        tick();
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 5'd5 || bus.instr_data !== 16'h0C05) begin errors++; $display("FAIL jump_target: got v %b pc %0d data %h want v 1 pc 5 data 0c05", bus.instr_valid, bus.instr_pc, bus.instr_data); end
    endtask

    task automatic test_wrap();
        apply_reset();
        bus.instr_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; bus.jump_en = 1'b1; bus.jump_addr = 5'd30;
        tick();
        bus.jump_en = 1'b0;
        vectors++; if (bus.instr_valid !== 1'b0 || bus.rom_addr !== 5'd30) begin errors++; $display("FAIL wrap_redirect: got v %b addr %0d want v 0 addr 30", bus.instr_valid, bus.rom_addr); end
        tick(); tick();
        vectors++; if (bus.instr_pc !== 5'd31 || bus.instr_data !== 16'h0C1F || bus.rom_addr !== 5'd0) begin errors++; $display("FAIL wrap_31: got pc %0d data %h addr %0d want pc 31 data 0c1f addr 0", bus.instr_pc, bus.instr_data, bus.rom_addr); end
        tick();
        vectors++; if (bus.instr_pc !== 5'd0 || bus.instr_data !== 16'h0C00) begin errors++; $display("FAIL wrap_0: got pc %0d data %h want pc 0 data 0c00", bus.instr_pc, bus.instr_data); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        vectors++; if (fifo_cnt_dbg !== 3'd3) begin errors++; $display("FAIL rstmid_prefill: got cnt %0d want 3", fifo_cnt_dbg); end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.rom_oe !== 1'b0 || bus.rom_addr !== 5'd0 || bus.instr_valid !== 1'b0 || bus.instr_data !== 16'h0 ||
            bus.instr_pc !== 5'd0 || halted !== 1'b0 || fifo_cnt_dbg !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_async: got oe %b addr %0d v %b data %h pc %0d halted %b cnt %0d want all 0", bus.rom_oe, bus.rom_addr, bus.instr_valid, bus.instr_data, bus.instr_pc, halted, fifo_cnt_dbg);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (bus.rom_oe !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle: cycle %0d got oe %b v %b want 0 0", i, bus.rom_oe, bus.instr_valid); end
        end
    endtask

    initial begin
        bus.jump_en = 1'b0; bus.jump_addr = '0; bus.instr_ready = 1'b0;
        load_rom();
        test_reset();
        test_stream();
        test_backpressure();
        test_halt();
        test_jump();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
